adc_capture_fifo: RTL and testbench
===================================

# adc_capture_fifo

Parametrised dual-clock capture FIFO between the ADC deserialiser (wrclk domain) and the host readout logic (rdclk domain). It stores raw ADC samples of up to DATA_W bits. At read time it presents each sample left-justified in an OUT_W-bit word, at the resolution selected by bw_bits. It also reports empty/full status and a sticky overflow flag, with no vendor FIFO primitives.

## Interface
- DATA_W, 14: stored sample width; legal range 14..OUT_W.
- OUT_W, 16: output word width.
- ADDR_W, 15: address width; depth = 2^ADDR_W (default 32768).
- SYNC_STAGES, 2: flip-flops per pointer synchroniser; minimum 2.
- rdclk  in  1  read clock; all read-side outputs are registered on its rising edge.
- rst  in  1  asynchronous, active-high reset for both domains; deassertion is synchronised separately into each domain.
- wrclk  in  1  write (sample) clock.
- din  in  DATA_W  raw sample, right-aligned.
- wren  in  1  write request (wrclk).
- rden  in  1  read request (rdclk).
- bw_bits  in  2  resolution: 00=8, 01=10, 10=12, 11=14 bits.
- dout  out  OUT_W  left-justified sample; reset 0.
- dout_valid  out  1  one-cycle pulse when dout is updated; reset 0.
- empty  out  1  no readable data (rdclk); reset 1.
- full  out  1  no writable space (wrclk); reset 1.
- overflow  out  1  sticky dropped-write flag in the rdclk domain; reset 0.

## Operation
- Storage: dual-port RAM of 2^ADDR_W × DATA_W entries.
- Pointers: each pointer is ADDR_W+1 bits, binary plus Gray. Gray pointers cross domains through SYNC_STAGES flip-flops.
- Write: when wren=1 and full=0 at a wrclk edge, din is stored and the write pointer increments. When wren=1 and full=1, the write is dropped, no state changes, and the wrclk-domain overflow bit is set.
- Read: when rden=1 and empty=0 at an rdclk edge, the entry at the read pointer is read and the read pointer increments. On the next edge, dout is loaded and dout_valid=1. When rden=1 and empty=1, the request is ignored: dout holds and dout_valid=0.
- Justification: N = 8 + 2·bw_bits. Then dout = {din[N-1:0], (OUT_W-N) zeros}, and upper stored bits are discarded. bw_bits is sampled on the same rdclk edge as the accepted rden.
- Wrap-around: pointers wrap modulo 2^(ADDR_W+1).
  - full = (write Gray pointer == synced read Gray pointer with its top two bits inverted).
  - empty = (read Gray pointer == synced write Gray pointer).
- Overflow: the wrclk-domain overflow bit is synchronised into rdclk by a 2-flop synchroniser. It stays set until rst.
- Simultaneous read and write while neither full nor empty: both are accepted, and the occupancy is unchanged.
- Reset asserted mid-operation:
  - Pointers, dout, dout_valid and overflow clear immediately, and all data is discarded.
  - empty=1 and full=1 immediately.
  - empty remains 1 until data is written after release.
  - full deasserts SYNC_STAGES+1 wrclk edges after rst is released.
  - No write or read is accepted while full or empty is held by reset.

## Timing
- Read latency: 1 rdclk cycle from an accepted rden to valid dout and dout_valid.
- Write-to-empty deassertion: at most SYNC_STAGES+1 rdclk edges after the accepting wrclk edge.
- Read-to-full deassertion: at most SYNC_STAGES+1 wrclk edges after the accepting rdclk edge.
- Flags are pessimistic: empty/full may stay asserted longer than true occupancy requires, but never shorter.
- Back-to-back rden: one sample per rdclk cycle, sustained until empty.
- Clocks are fully asynchronous with any frequency ratio.

## Configuration
- Macro: ADC_CAPTURE_OFFSET_BIN_CONV_EN.
- Defined: the selected N-bit field is converted from offset binary to two's complement (bit N-1 inverted) before justification.
- Undefined: the field passes unmodified, identical to the description above.
- Storage, flags and timing are identical in both builds.

## Test plan
- Reset with rst=1 -> dout=0x0000, dout_valid=0, empty=1, full=1, overflow=0; full=0 within 3 wrclk edges after release.
- bw_bits=11: write 0x1ABC then 0x0123; two reads -> dout 0x6AF0 then 0x048C, each with a one-cycle dout_valid pulse at 1-cycle latency.
- bw_bits=00 with din=0x3FA5 -> dout=0xA500; bw_bits=10 with din=0x0FFF -> dout=0xFFF0.
- ADDR_W=4, 16 writes -> full=1; a 17th write (0x0111) is dropped and overflow=1 within 3 rdclk edges. Then 16 reads return the data in order, then empty=1. An extra rden keeps dout unchanged with dout_valid=0. The pointer wrap is then exercised by a further 40 writes and reads with no data loss.
- rst pulse during a back-to-back read burst -> empty=1 and overflow=0 immediately. After release, writing 0x0AAA at bw_bits=11 and reading back gives 0x2AA8, with no stale data.
- With ADC_CAPTURE_OFFSET_BIN_CONV_EN defined, bw_bits=11: din=0x2000 -> dout=0x0000; din=0x0000 -> dout=0x8000.

Source files
------------

// File: rtl/adc_capture_fifo_if.sv
// ============================================================================
// adc_capture_fifo_if : sample/readout bundle of the dual-clock ADC capture FIFO
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_capture_fifo_if #(
  parameter int DATA_W = 14,
  parameter int OUT_W  = 16
);
  logic [DATA_W-1:0] din;
  logic              wren;
  logic              rden;
  logic [1:0]        bw_bits;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    output din, wren, rden, bw_bits,
    input  dout, dout_valid, empty, full, overflow
  );

  modport slave (
    input  din, wren, rden, bw_bits,
    output dout, dout_valid, empty, full, overflow
  );
endinterface

`default_nettype wire

// File: rtl/adc_capture_fifo.sv
// ============================================================================
// adc_capture_fifo : Gray-pointer dual-clock FIFO with left-justified readout.
// Option macro ADC_CAPTURE_OFFSET_BIN_CONV_EN: offset-binary to two's complement.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_capture_fifo #(
  parameter int DATA_W      = 14,
  parameter int OUT_W       = 16,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic rdclk,
  input  logic wrclk,
  input  logic rst,
  adc_capture_fifo_if.slave bus
);

`ifdef ADC_CAPTURE_OFFSET_BIN_CONV_EN
  localparam logic SIGN_FLIP = 1'b1;
`else
  localparam logic SIGN_FLIP = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // ---------------- write domain ----------------
  logic [SYNC_STAGES-1:0]           wrst_q;
  logic [ADDR_W:0]                  wbin_q, wbin_d, wgray_q, wgray_d;
  logic [SYNC_STAGES-1:0][ADDR_W:0] rgray_sync_q;
  logic                             full_q, full_d, wovf_q, wr_en;
  logic [ADDR_W:0]                  rgray_q;

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) wrst_q <= '1;
    else     wrst_q <= {wrst_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_comb begin
    wr_en   = bus.wren && !full_q;
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wr_en};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the write side has lapped the read side: top two Gray bits differ.
    full_d  = (wgray_d == {~rgray_sync_q[SYNC_STAGES-1][ADDR_W -: 2],
                           rgray_sync_q[SYNC_STAGES-1][ADDR_W-2:0]});
  end

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      wbin_q       <= '0;
      wgray_q      <= '0;
      rgray_sync_q <= '0;
      full_q       <= 1'b1;
      wovf_q       <= 1'b0;
    end else begin
      wbin_q       <= wbin_d;
      wgray_q      <= wgray_d;
      rgray_sync_q <= {rgray_sync_q[SYNC_STAGES-2:0], rgray_q};
      full_q       <= wrst_q[SYNC_STAGES-1] | full_d;
      if (bus.wren && full_q && !wrst_q[SYNC_STAGES-1]) wovf_q <= 1'b1;
    end
  end

  always_ff @(posedge wrclk) begin
    if (wr_en) mem_q[wbin_q[ADDR_W-1:0]] <= bus.din;
  end

  // ---------------- read domain ----------------
  logic [SYNC_STAGES-1:0]           rrst_q;
  logic [ADDR_W:0]                  rbin_q, rbin_d, rgray_d;
  logic [SYNC_STAGES-1:0][ADDR_W:0] wgray_sync_q;
  logic                             empty_q, empty_d, rd_en, rd_pend_q;
  logic [1:0]                       ovf_sync_q, bw_q;
  logic [DATA_W-1:0]                rd_data_q;
  logic [OUT_W-1:0]                 ext, just, dout_q;
  logic                             dout_valid_q;

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) rrst_q <= '1;
    else     rrst_q <= {rrst_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_comb begin
    rd_en   = bus.rden && !empty_q;
    rbin_d  = rbin_q + {{ADDR_W{1'b0}}, rd_en};
    rgray_d = rbin_d ^ (rbin_d >> 1);
    empty_d = (rgray_d == wgray_sync_q[SYNC_STAGES-1]);
  end

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      wgray_sync_q <= '0;
      empty_q      <= 1'b1;
      ovf_sync_q   <= '0;
      rd_pend_q    <= 1'b0;
      bw_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      wgray_sync_q <= {wgray_sync_q[SYNC_STAGES-2:0], wgray_q};
      empty_q      <= rrst_q[SYNC_STAGES-1] | empty_d;
      ovf_sync_q   <= {ovf_sync_q[0], wovf_q};
      rd_pend_q    <= rd_en;
      if (rd_en) bw_q <= bus.bw_bits;
      dout_valid_q <= rd_pend_q;
      if (rd_pend_q) dout_q <= just;
    end
  end

  // RAM output register; contents are only ever used behind rd_pend_q.
  always_ff @(posedge rdclk) begin
    if (rd_en) rd_data_q <= mem_q[rbin_q[ADDR_W-1:0]];
  end

  // Shifting the right-aligned sample pushes the unused upper bits off the top.
  always_comb begin
    ext                = '0;
    ext[DATA_W-1:0]    = rd_data_q;
    case (bw_q)
      2'b00:   just = ext << (OUT_W - 8);
      2'b01:   just = ext << (OUT_W - 10);
      2'b10:   just = ext << (OUT_W - 12);
      default: just = ext << (OUT_W - 14);
    endcase
    just[OUT_W-1] = just[OUT_W-1] ^ SIGN_FLIP;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.overflow   = ovf_sync_q[1];

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_fifo.sv
// ============================================================================
// tb_adc_capture_fifo : self-checking bench for adc_capture_fifo (ADDR_W=4)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_capture_fifo;

  localparam int DEPTH = 16;

  logic rdclk, wrclk, rst;
  int   total, bad;

  logic [13:0] q[$];
  logic [15:0] last_exp;

  adc_capture_fifo_if #(.DATA_W(14), .OUT_W(16)) bus ();

  adc_capture_fifo #(
    .DATA_W(14), .OUT_W(16), .ADDR_W(4), .SYNC_STAGES(2)
  ) dut (
    .rdclk(rdclk),
    .wrclk(wrclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial begin wrclk = 1'b0; forever #5 wrclk = ~wrclk; end
  initial begin rdclk = 1'b0; forever #7 rdclk = ~rdclk; end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: keep the N low bits, optionally flip the top one, park at the MSB end.
  function automatic logic [15:0] justify(input logic [13:0] s, input logic [1:0] bw);
    int n, field;
    n     = 8 + 2 * int'(bw);
    field = int'(s) % (1 << n);
`ifdef ADC_CAPTURE_OFFSET_BIN_CONV_EN
    field = field ^ (1 << (n - 1));
`endif
    return 16'(field * (1 << (16 - n)));
  endfunction

  task automatic wr_push(input logic [13:0] d);
    int n;
    @(posedge wrclk); #1;
    n = 0;
    while (bus.full && n < 100) begin @(posedge wrclk); #1; n++; end
    if (bus.full) begin
      total++; bad++;
      $display("FAIL wr_wait: full=%0b stuck, required 0", bus.full);
      return;
    end
    bus.din = d; bus.wren = 1'b1;
    @(posedge wrclk); #1;
    bus.wren = 1'b0;
    q.push_back(d);
    if (q.size() == DEPTH) begin
      total++;
      if (bus.full !== 1'b1) begin bad++; $display("FAIL full_at_depth: full=%0b required 1", bus.full); end
    end
  endtask

  task automatic rd_one(input logic [1:0] bw);
    int n;
    logic [15:0] e;
    @(posedge rdclk); #1;
    n = 0;
    while (bus.empty && n < 100) begin @(posedge rdclk); #1; n++; end
    if (bus.empty) begin
      total++; bad++;
      $display("FAIL rd_wait: empty=%0b stuck, required 0", bus.empty);
      return;
    end
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL empty_no_data: empty=%0b required 1", bus.empty);
      return;
    end
    bus.bw_bits = bw; bus.rden = 1'b1;
    @(posedge rdclk); #1;
    bus.rden = 1'b0;
    e = justify(q.pop_front(), bw);
    total++;
    if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL valid_early: dout_valid=%0b required 0", bus.dout_valid); end
    if (q.size() == 0) begin
      total++;
      if (bus.empty !== 1'b1) begin bad++; $display("FAIL empty_after_last: empty=%0b required 1", bus.empty); end
    end
    @(posedge rdclk); #1;
    total++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== e) begin
      bad++;
      $display("FAIL read_data: dout=%h valid=%0b required dout=%h valid=1", bus.dout, bus.dout_valid, e);
    end
    last_exp = e;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge rdclk); #1;
    total += 5;
    if (bus.dout !== 16'h0000)  begin bad++; $display("FAIL rst_dout: %h required 0000", bus.dout); end
    if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: %0b required 0", bus.dout_valid); end
    if (bus.empty !== 1'b1)      begin bad++; $display("FAIL rst_empty: %0b required 1", bus.empty); end
    if (bus.full !== 1'b1)       begin bad++; $display("FAIL rst_full: %0b required 1", bus.full); end
    if (bus.overflow !== 1'b0)   begin bad++; $display("FAIL rst_ovf: %0b required 0", bus.overflow); end
    @(negedge wrclk); rst = 1'b0;
    repeat (2) @(posedge wrclk); #1;
    total++;
    if (bus.full !== 1'b1) begin bad++; $display("FAIL full_hold: full=%0b required 1 at edge 2", bus.full); end
    @(posedge wrclk); #1;
    total++;
    if (bus.full !== 1'b0) begin bad++; $display("FAIL full_release: full=%0b required 0 at edge 3", bus.full); end
    repeat (4) @(posedge rdclk); #1;
    total++;
    if (bus.empty !== 1'b1) begin bad++; $display("FAIL empty_release: empty=%0b required 1", bus.empty); end
  endtask

  task automatic test_justify();
    wr_push(14'h1ABC);
    wr_push(14'h0123);
    rd_one(2'b11);
    rd_one(2'b11);
    @(posedge rdclk); #1;
    total++;
    if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse: dout_valid=%0b required 0", bus.dout_valid); end
    wr_push(14'h3FA5); rd_one(2'b00);
    wr_push(14'h0FFF); rd_one(2'b10);
    wr_push(14'h2AA5); rd_one(2'b01);
  endtask

  task automatic test_offset();
    wr_push(14'h2000);
    wr_push(14'h0000);
    rd_one(2'b11);
    rd_one(2'b11);
  endtask

  task automatic test_full_overflow();
    int n;
    for (int i = 0; i < DEPTH; i++) wr_push(14'($urandom));
    @(posedge wrclk); #1;
    total++;
    if (bus.full !== 1'b1) begin bad++; $display("FAIL full_before_drop: full=%0b required 1", bus.full); end
    bus.din = 14'h0111; bus.wren = 1'b1;
    @(posedge wrclk); #1;
    bus.wren = 1'b0;
    n = 0;
    while (!bus.overflow && n < 3) begin @(posedge rdclk); #1; n++; end
    total++;
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: overflow=%0b required 1", bus.overflow); end
    for (int i = 0; i < DEPTH; i++) rd_one(2'($urandom));
    @(posedge rdclk); #1;
    bus.rden = 1'b1;
    @(posedge rdclk); #1;
    bus.rden = 1'b0;
    @(posedge rdclk); #1;
    total++;
    if (bus.dout !== last_exp || bus.dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_read: dout=%h valid=%0b required dout=%h valid=0", bus.dout, bus.dout_valid, last_exp);
    end
    total++;
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: overflow=%0b required 1", bus.overflow); end
  endtask

  task automatic test_wrap();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge wrclk);
          wr_push(14'($urandom));
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge rdclk);
          rd_one(2'($urandom));
        end
      end
    join
  endtask

  task automatic test_back_to_back_reset();
    logic [15:0] exp_q[$];
    logic [15:0] e;
    for (int i = 0; i < 8; i++) wr_push(14'($urandom));
    repeat (6) @(posedge rdclk);
    @(posedge rdclk); #1;
    bus.bw_bits = 2'b11; bus.rden = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge rdclk); #1;
      exp_q.push_back(justify(q.pop_front(), 2'b11));
      if (i > 0) begin
        e = exp_q.pop_front();
        total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== e) begin
          bad++;
          $display("FAIL burst_data: dout=%h valid=%0b required dout=%h valid=1", bus.dout, bus.dout_valid, e);
        end
      end
    end
    @(negedge wrclk); rst = 1'b1;
    #1;
    bus.rden = 1'b0;
    total += 5;
    if (bus.empty !== 1'b1)      begin bad++; $display("FAIL midrst_empty: %0b required 1", bus.empty); end
    if (bus.full !== 1'b1)       begin bad++; $display("FAIL midrst_full: %0b required 1", bus.full); end
    if (bus.overflow !== 1'b0)   begin bad++; $display("FAIL midrst_ovf: %0b required 0", bus.overflow); end
    if (bus.dout !== 16'h0000)   begin bad++; $display("FAIL midrst_dout: %h required 0000", bus.dout); end
    if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: %0b required 0", bus.dout_valid); end
    q.delete();
    repeat (3) @(negedge wrclk);
    rst = 1'b0;
    wr_push(14'h0AAA);
    rd_one(2'b11);
  endtask

  initial begin
    total = 0; bad = 0;
    last_exp = '0;
    rst = 1'b1;
    bus.din = '0; bus.wren = 1'b0; bus.rden = 1'b0; bus.bw_bits = 2'b00;
    test_reset();
    test_justify();
    test_offset();
    test_full_overflow();
    test_wrap();
    test_back_to_back_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
